// File: rtl/vga_fb_pkg.sv
// Shared constants and FSM state type for the VGA framebuffer arbiter.
package vga_fb_pkg;

  localparam int DEF_ADDR_W    = 19;
  localparam int DEF_PIX_W     = 3;
  localparam int H_RES         = 640;
  localparam int V_RES         = 480;
  localparam int DEF_FRAME_PIX = H_RES * V_RES;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_DISP  = 2'd1,
    ST_WRITE = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_addr_counter.sv
// Display read address: advances on each active pixel, clears at frame start
// (which wins over advancing) and wraps at the end of the frame.
module fb_addr_counter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAME_PIX = DEF_FRAME_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              advance,
  output logic [ADDR_W-1:0] disp_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;

  always_comb begin
    disp_addr_d = disp_addr_q;
    if (frame_start) begin
      disp_addr_d = '0;
    end else if (advance) begin
      disp_addr_d = (disp_addr_q == LAST_ADDR) ? '0 : disp_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp_addr_q <= '0;
    else     disp_addr_q <= disp_addr_d;
  end

  assign disp_addr = disp_addr_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one sync RAM port between the VGA display read path and a writer.
// Optional stall counter output is enabled by defining FB_ARB_STATS_EN.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int FRAME_PIX = DEF_FRAME_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_active,
  input  logic              v_active,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  rgb_out,
  output logic              rgb_valid
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]       wr_stall_cnt
`endif
);

  fb_state_t         state_q, state_d;
  logic              v_active_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic [2:0]        rd_vld_q, rd_vld_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [PIX_W-1:0]  rgb_out_q, rgb_out_d;
  logic              rgb_valid_q, rgb_valid_d;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp, frame_start, grant, wr_in_range;

  assign disp        = h_active & v_active;
  assign frame_start = v_active & ~v_active_q;
  // A cycle in WRITE is exactly a cycle with wr_ack high, so this spaces grants.
  assign grant       = ~disp & wr_req & (state_q != ST_WRITE);
  assign wr_in_range = wr_addr < ADDR_W'(FRAME_PIX);

  fb_addr_counter #(
    .ADDR_W   (ADDR_W),
    .FRAME_PIX(FRAME_PIX)
  ) u_addr_cnt (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .advance    (disp),
    .disp_addr  (disp_addr)
  );

  always_comb begin
    state_d     = ST_BLANK;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    wr_ack_d    = 1'b0;
    if (disp) begin
      state_d    = ST_DISP;
      mem_addr_d = disp_addr;
    end else if (grant) begin
      state_d     = ST_WRITE;
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
      mem_we_d    = wr_in_range;
      wr_ack_d    = 1'b1;
    end
  end

  // Address at edge k, RAM data at k+1, captured at k+2, presented at k+3.
  always_comb begin
    rd_vld_d    = {rd_vld_q[1:0], disp};
    pix_d       = rd_vld_q[1] ? mem_rdata : '0;
    rgb_valid_d = rd_vld_q[2];
    rgb_out_d   = rd_vld_q[2] ? pix_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      v_active_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      rd_vld_q    <= '0;
      pix_q       <= '0;
      rgb_out_q   <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_active_q  <= v_active;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      rd_vld_q    <= rd_vld_d;
      pix_q       <= pix_d;
      rgb_out_q   <= rgb_out_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_ack    = wr_ack_q;
  assign rgb_out   = rgb_out_q;
  assign rgb_valid = rgb_valid_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (wr_req && !grant && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign wr_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a shrunken 8x4 frame with a model RAM.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 19;
  localparam int PIX_W  = 3;
  localparam int H_ACT  = 8;
  localparam int V_ACT  = 4;
  localparam int H_BP   = 2;
  localparam int H_TOT  = 12;
  localparam int FP     = H_ACT * V_ACT;

  logic              clk = 1'b0;
  logic              rst, h_active, v_active, wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ack, mem_we, rgb_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata, mem_rdata, rgb_out;
`ifdef FB_ARB_STATS_EN
  logic [15:0]       wr_stall_cnt;
`endif

  logic [PIX_W-1:0]  ram [0:63];
  int                n_checks = 0;
  int                n_pass   = 0;
  int                exp_pix, n_valid, acks;
  logic              prev_v, pending;
  logic [2:0]        pv;
  logic [PIX_W-1:0]  pd [0:2];

  vga_fb_arbiter #(
    .ADDR_W   (ADDR_W),
    .PIX_W    (PIX_W),
    .FRAME_PIX(FP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .h_active (h_active),
    .v_active (v_active),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rgb_out  (rgb_out),
    .rgb_valid(rgb_valid)
`ifdef FB_ARB_STATS_EN
    ,
    .wr_stall_cnt(wr_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= PIX_W'(i * 3 + 1);
    end else if (mem_we) begin
      ram[mem_addr[5:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[5:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_addr"},  32'(mem_addr),  32'd0);
    check_eq({tag, "_we"},    32'(mem_we),    32'd0);
    check_eq({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_ack"},   32'(wr_ack),    32'd0);
    check_eq({tag, "_rgb"},   32'(rgb_out),   32'd0);
    check_eq({tag, "_vld"},   32'(rgb_valid), 32'd0);
  endtask

  // One clock; checks the read pipeline and the display address against the model.
  task automatic tick();
    logic d, r;
    d = h_active & v_active;
    r = v_active & ~prev_v;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_pix = 0; prev_v = 1'b0; pv = '0;
      pd[0] = '0; pd[1] = '0; pd[2] = '0;
      return;
    end
    check_eq("rgb_valid", 32'(rgb_valid), 32'(pv[2]));
    check_eq("rgb_out", 32'(rgb_out), pv[2] ? 32'(pd[2]) : 32'd0);
    if (rgb_valid) n_valid++;
    pv = {pv[1:0], d};
    pd[2] = pd[1];
    pd[1] = pd[0];
    pd[0] = '0;
    if (d) begin
      check_eq("disp_addr", 32'(mem_addr), 32'(exp_pix));
      check_eq("disp_we", 32'(mem_we), 32'd0);
      pd[0] = ram[exp_pix[5:0]];
    end
    exp_pix = r ? 0 : (d ? (exp_pix + 1) % FP : exp_pix);
    prev_v  = v_active;
  endtask

  task automatic run_frame(input int act_lines, input int rst_line, input int req_line);
    logic d;
    for (int vc = 0; vc < act_lines + 2; vc++) begin
      for (int hc = 0; hc < H_TOT; hc++) begin
        v_active = (vc < act_lines);
        h_active = (hc >= H_BP) && (hc < H_BP + H_ACT);
        rst      = (vc == rst_line) && (hc == H_BP + 3);
        if (vc == req_line && hc == H_BP + 2) begin
          wr_req = 1'b1; wr_addr = 20; wr_data = 3'b110; pending = 1'b1;
        end
        d = h_active & v_active;
        tick();
        if (rst) begin
          check_idle_zero("midline_rst");
          rst = 1'b0;
        end else if (pending) begin
          check_eq("stall_ack", 32'(wr_ack), 32'(!d));
          if (wr_ack) begin
            check_eq("stall_we",    32'(mem_we),    32'd1);
            check_eq("stall_addr",  32'(mem_addr),  32'd20);
            check_eq("stall_wdata", 32'(mem_wdata), 32'd6);
            $display("stalled write acked line %0d col %0d", vc, hc);
            wr_req = 1'b0; pending = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; h_active = 1'b0; v_active = 1'b0; wr_req = 1'b0;
    wr_addr = '0; wr_data = '0; pending = 1'b0; n_valid = 0;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;

    n_valid = 0;
    run_frame(V_ACT, -1, 0);
    check_eq("frame_valid_cnt", 32'(n_valid), 32'(FP));
    check_eq("stall_ack_seen", 32'(pending), 32'd0);
    wr_req = 1'b0; pending = 1'b0;

    run_frame(V_ACT, 1, -1);

    n_valid = 0;
    run_frame(V_ACT + 1, -1, -1);
    check_eq("wrap_valid_cnt", 32'(n_valid), 32'(FP + H_ACT));

    wr_req = 1'b1; wr_addr = 5; wr_data = 3'b101;
    tick();
    check_eq("blank_ack",   32'(wr_ack),    32'd1);
    check_eq("blank_we",    32'(mem_we),    32'd1);
    check_eq("blank_addr",  32'(mem_addr),  32'd5);
    check_eq("blank_wdata", 32'(mem_wdata), 32'd5);
    $display("write addr=5 data=101 ack=%0b we=%0b", wr_ack, mem_we);
    wr_req = 1'b0;
    tick();
    check_eq("blank_ack_drop", 32'(wr_ack),   32'd0);
    check_eq("blank_we_drop",  32'(mem_we),   32'd0);
    check_eq("blank_addr_hold", 32'(mem_addr), 32'd5);
    check_eq("blank_ram5",     32'(ram[5]),   32'd5);

    wr_req = 1'b1; wr_addr = ADDR_W'(FP); wr_data = 3'b111;
    tick();
    check_eq("oor_ack", 32'(wr_ack), 32'd1);
    check_eq("oor_we",  32'(mem_we), 32'd0);
    $display("write addr=%0d (out of range) ack=%0b we=%0b", FP, wr_ack, mem_we);
    wr_req = 1'b0;
    tick();
    check_eq("oor_ack_drop", 32'(wr_ack), 32'd0);

    acks = 0; wr_req = 1'b1; wr_addr = 10; wr_data = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("burst_ack%0d", i), 32'(wr_ack), 32'(i % 2 == 0));
      if (wr_ack) begin
        check_eq("burst_addr", 32'(mem_addr), 32'(10 + acks));
        $display("burst write %0d addr=%0d ack", acks, mem_addr);
        acks++;
        wr_addr = ADDR_W'(10 + acks);
        wr_data = PIX_W'(acks);
      end
    end
    wr_req = 1'b0;
    tick();
    check_eq("burst_acks", 32'(acks), 32'd5);
    check_eq("burst_ram12", 32'(ram[12]), 32'd2);
    check_eq("burst_ram14", 32'(ram[14]), 32'd4);

    rst = 1'b1;
    tick();
    check_idle_zero("rst2");
    rst = 1'b0;
    h_active = 1'b1; v_active = 1'b1; wr_req = 1'b1; wr_addr = 3; wr_data = 3'b001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("disp_no_ack", 32'(wr_ack), 32'd0);
    end
`ifdef FB_ARB_STATS_EN
    check_eq("stall_cnt", 32'(wr_stall_cnt), 32'd20);
`endif
    h_active = 1'b0;
    tick();
    check_eq("post_disp_ack",  32'(wr_ack),   32'd1);
    check_eq("post_disp_addr", 32'(mem_addr), 32'd3);
    wr_req = 1'b0; v_active = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, framebuffer address width.
REQ-002 Parameter PIX_W, default 3, pixel width (r,g,b bits).
REQ-003 Parameter FRAME_PIX, default 307200, pixels per frame (640x480).
REQ-004 Port clk  in  1  pixel clock; all logic on posedge clk.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port h_active, v_active  in  1 each  display-enable flags from the timing generator (hDisplay/vDisplay).
REQ-007 Port wr_req  in  1  writer request; wr_addr in ADDR_W and wr_data in PIX_W are held stable while wr_req=1.
REQ-008 Port wr_ack  out  1  one-cycle pulse: request consumed.
REQ-009 Port mem_addr  out  ADDR_W;  mem_we  out  1;  mem_wdata  out  PIX_W  single-port sync RAM controls, all registered.
REQ-010 Port mem_rdata  in  PIX_W  RAM read data, valid one cycle after mem_addr.
REQ-011 Port rgb_out  out  PIX_W;  rgb_valid  out  1  registered pixel to the VGA RGB stage.

Function
REQ-012 disp = h_active & v_active, sampled at each posedge.
REQ-013 FSM states BLANK, DISP, WRITE; next state DISP when disp=1, else WRITE when write granted, else BLANK.
REQ-014 DISP: mem_addr<=disp_addr, mem_we<=0, disp_addr<=disp_addr+1; display always has priority over writer.
REQ-015 Write grant: disp=0 & wr_req=1 & wr_ack=0; at most one write per two cycles.
REQ-016 WRITE: mem_addr<=wr_addr, mem_wdata<=wr_data, mem_we<=1, wr_ack<=1, all in the same cycle.
REQ-017 wr_addr >= FRAME_PIX: wr_ack still pulses, mem_we stays 0; no write.
REQ-018 wr_req=1 during disp=1: request stalls, no ack, until the first blanking cycle.
REQ-019 disp_addr clears to 0 on the cycle a rising edge of v_active is detected (via registered v_active), overriding increment.
REQ-020 disp_addr wraps FRAME_PIX-1 -> 0.
REQ-021 Read latency: disp sampled at edge k -> rgb_out/rgb_valid updated at edge k+3; timing generator compensates.
REQ-022 rgb_out = 0 whenever rgb_valid = 0 (blanking black).
REQ-023 BLANK: mem_we<=0, mem_addr holds value, wr_ack<=0.

Reset
REQ-024 While rst=1: state=BLANK, disp_addr=0, mem_addr=0, mem_we=0, mem_wdata=0, wr_ack=0, rgb_out=0, rgb_valid=0, pipeline valid bits 0.
REQ-025 Reset mid-write: no ack issued; requester retries after release.
REQ-026 First frame after release starts at address 0 regardless of v_active level at release.

Configuration
REQ-027 Macro FB_ARB_STATS_EN defined: adds output wr_stall_cnt (16 bits), +1 per cycle with wr_req=1 & no grant, saturating at 0xFFFF, cleared by rst.
REQ-028 FB_ARB_STATS_EN undefined: port and counter are absent; all other behaviour identical.

Structure
REQ-029 Shared package vga_fb_pkg holds ADDR_W, PIX_W, FRAME_PIX defaults, H_RES=640, V_RES=480, and the FSM state typedef.
REQ-030 Sub-module fb_addr_counter: disp_addr register with increment, frame-start clear and wrap.

Verification
REQ-031 rst pulse mid-line -> all outputs 0 next cycle; first active pixel reads mem_addr=0.
REQ-032 Full 800x525 frame, no writes -> mem_addr sweeps 0..307199 exactly once; rgb_valid high for 307200 cycles; rgb_out=mem_rdata delayed correctly.
REQ-033 wr_req with addr=5, data=3b101 during blanking -> next cycle mem_we=1, mem_addr=5, mem_wdata=101, wr_ack=1.
REQ-034 wr_req asserted mid-line -> no wr_ack until the first cycle after h_active falls; no display read lost.
REQ-035 wr_req held high for 10 blanking cycles with new addrs after each ack -> exactly 5 acks, alternating cycles.
REQ-036 wr_addr=307200 -> wr_ack pulses, mem_we stays 0; with FB_ARB_STATS_EN, 20 stalled cycles -> wr_stall_cnt=20.
